// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//
// Contents:
//   state_t      - control FSM state encoding
//   ctrl_t       - raw per-state datapath control bundle (before reset gating)
//   OP_*         - instr[31:26] opcodes handled by the controller
//   FN_*         - instr[5:0] funct codes for R-type ALU operations
//   ALU_*        - 3-bit ALU control encodings
//   ALUOP_*      - ALU operation class handed to the ALU decoder
//   PCSRC_*      - PC source mux select encodings
//   SRCB_*       - ALU operand B mux select encodings
//   is_known_op  - true for every opcode the controller can sequence
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control encodings
  typedef logic [2:0] alu_ctrl_t;
  localparam alu_ctrl_t ALU_AND = 3'b000;
  localparam alu_ctrl_t ALU_OR  = 3'b001;
  localparam alu_ctrl_t ALU_ADD = 3'b010;
  localparam alu_ctrl_t ALU_SUB = 3'b110;
  localparam alu_ctrl_t ALU_SLT = 3'b111;

  // ALU operation class: fixed add, fixed subtract, or decode from funct
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic [1:0] pc_src;
    logic       reg_write_en;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: maps an ALU operation class plus the R-type
// funct field onto the 3-bit ALU control code.
//
// Ports:
//   alu_op_i        in  2  ALUOP_ADD / ALUOP_SUB / ALUOP_FUNCT
//   funct_i         in  6  instr[5:0]
//   alu_control_o   out 3  ALU_* encoding
//   funct_illegal_o out 1  funct not recognised while alu_op_i = ALUOP_FUNCT
module mips_alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output alu_ctrl_t  alu_control_o,
  output logic       funct_illegal_o
);

  always_comb begin
    alu_control_o   = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_SLT:  alu_control_o = ALU_SLT;
          default: begin
            // Unknown funct still executes as add so the datapath stays defined.
            alu_control_o   = ALU_ADD;
            funct_illegal_o = 1'b1;
          end
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM. Sequences PC, IR, register file, ALU and the
// unified instruction/data memory over several cycles per instruction.
//
// Memory handshake: mem_req (qualified by mem_write for stores) is held high
// for as long as the FSM sits in a memory state; the access completes in the
// cycle mem_ready=1, and only then does the FSM advance. mem_ready in any
// other state is ignored.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-high reset
//   opcode, funct     instruction fields from IR
//   zero              ALU zero flag (same cycle)
//   mem_ready         memory accepted/completed the access this cycle
//   mem_req/mem_write memory request / store qualifier
//   iord              memory address select (0 PC, 1 ALUOut)
//   ir_write, pc_en   IR load, PC register enable
//   pc_src            PC source select
//   reg_write_en      register file write enable
//   reg_dst           write address select (0 rt, 1 rd)
//   mem_to_reg        write data select (0 ALUOut, 1 MDR)
//   alu_src_a/b       ALU operand selects
//   alu_control       ALU operation
//   illegal_op        unknown opcode/funct flag (sticky when ILLEGAL_TRAP=1)
//   dbg_state         current FSM state
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_write_en,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       illegal_op,
  output state_t     dbg_state
);

  state_t    state_q, state_d;
  logic      illegal_q, illegal_d;
  ctrl_t     ctl;
  logic      pc_write;
  logic      branch;
  logic      alu_active;
  logic [1:0] alu_op;
  logic      opcode_illegal;
  logic      funct_illegal;
  logic      illegal_now;
  alu_ctrl_t dec_alu;

  mips_alu_decoder u_alu_dec (
    .alu_op_i        (alu_op),
    .funct_i         (funct),
    .alu_control_o   (dec_alu),
    .funct_illegal_o (funct_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ctl            = '0;
    pc_write       = 1'b0;
    branch         = 1'b0;
    alu_active     = 1'b0;
    alu_op         = ALUOP_ADD;
    opcode_illegal = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // PC + 4 is computed while the instruction is read; both land together.
        ctl.mem_req   = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        alu_active    = 1'b1;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          pc_write     = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        ctl.alu_src_b = SRCB_IMM_SH2;
        alu_active    = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            opcode_illegal = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        alu_active    = 1'b1;
        state_d       = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.reg_write_en = 1'b1;
        ctl.mem_to_reg   = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEMWR: begin
        ctl.mem_req   = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        alu_active    = 1'b1;
        alu_op        = ALUOP_FUNCT;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.reg_write_en = 1'b1;
        ctl.reg_dst      = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_REG;
        ctl.pc_src    = PCSRC_ALUOUT;
        alu_active    = 1'b1;
        alu_op        = ALUOP_SUB;
        branch        = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        alu_active    = 1'b1;
        state_d       = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl.reg_write_en = 1'b1;
        state_d          = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_src = PCSRC_JUMP;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // funct_illegal can only rise in EXECUTE, the one state selecting ALUOP_FUNCT.
  assign illegal_now = opcode_illegal | funct_illegal;
  assign illegal_d   = ILLEGAL_TRAP ? (illegal_q | illegal_now) : 1'b0;

  // Enables are gated by reset so an abandoned instruction writes nothing.
  assign mem_req      = ctl.mem_req & ~reset;
  assign mem_write    = ctl.mem_write & ~reset;
  assign ir_write     = ctl.ir_write & ~reset;
  assign pc_en        = (pc_write | (branch & zero)) & ~reset;
  assign reg_write_en = ctl.reg_write_en & ~reset;
  assign illegal_op   = (illegal_now | (ILLEGAL_TRAP & illegal_q)) & ~reset;

  assign iord        = ctl.iord;
  assign pc_src      = ctl.pc_src;
  assign reg_dst     = ctl.reg_dst;
  assign mem_to_reg  = ctl.mem_to_reg;
  assign alu_src_a   = ctl.alu_src_a;
  assign alu_src_b   = ctl.alu_src_b;
  // ALU control reads as zero in states that do not use the ALU.
  assign alu_control = alu_active ? dec_alu : 3'b000;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl. Each table row is one clock
// cycle: the inputs for that cycle and the control outputs expected while
// the FSM sits in the stated state. A second instance with ILLEGAL_TRAP=1
// shares the inputs and is checked for its sticky illegal flag.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req0, mem_write0, iord0, ir_write0, pc_en0;
  logic [1:0] pc_src0, alu_src_b0;
  logic       reg_write_en0, reg_dst0, mem_to_reg0, alu_src_a0, illegal_op0;
  logic [2:0] alu_control0;
  state_t     dbg_state0;

  logic       mem_req1, mem_write1, iord1, ir_write1, pc_en1;
  logic [1:0] pc_src1, alu_src_b1;
  logic       reg_write_en1, reg_dst1, mem_to_reg1, alu_src_a1, illegal_op1;
  logic [2:0] alu_control1;
  state_t     dbg_state1;

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req0), .mem_write(mem_write0),
    .iord(iord0), .ir_write(ir_write0), .pc_en(pc_en0), .pc_src(pc_src0),
    .reg_write_en(reg_write_en0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_control(alu_control0),
    .illegal_op(illegal_op0), .dbg_state(dbg_state0)
  );

  mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req1), .mem_write(mem_write1),
    .iord(iord1), .ir_write(ir_write1), .pc_en(pc_en1), .pc_src(pc_src1),
    .reg_write_en(reg_write_en1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_control(alu_control1),
    .illegal_op(illegal_op1), .dbg_state(dbg_state1)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  logic [16:0] act0, act1;
  assign act0 = {mem_req0, mem_write0, iord0, ir_write0, pc_en0, pc_src0, reg_write_en0,
                 reg_dst0, mem_to_reg0, alu_src_a0, alu_src_b0, alu_control0, illegal_op0};
  assign act1 = {mem_req1, mem_write1, iord1, ir_write1, pc_en1, pc_src1, reg_write_en1,
                 reg_dst1, mem_to_reg1, alu_src_a1, alu_src_b1, alu_control1, illegal_op1};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic        chk;
    state_t      st;
    logic [16:0] exp;
    logic [16:0] mask;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Field order: mem_req mem_write iord ir_write pc_en pc_src reg_write_en
  //              reg_dst mem_to_reg alu_src_a alu_src_b alu_control illegal_op
  function automatic logic [16:0] mk(input logic mr, input logic mw, input logic io,
                                     input logic irw, input logic pe, input logic [1:0] ps,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic asa, input logic [1:0] asb,
                                     input logic [2:0] ac, input logic ill);
    return {mr, mw, io, irw, pe, ps, rw, rd, m2r, asa, asb, ac, ill};
  endfunction

  logic [16:0] m_all, m_en, m_no_ill;
  logic [16:0] e_fetch_rdy, e_fetch_wait, e_decode, e_decode_ill, e_memadr, e_memrd;
  logic [16:0] e_memwb, e_memwr, e_aluwb, e_br1, e_br0, e_addiwb, e_jump;

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input state_t st, input logic [16:0] exp);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
    v.chk = 1'b1; v.st = st; v.exp = exp; v.mask = m_all;
    vecs.push_back(v);
  endtask

  // Reset cycle: only the enables and illegal_op have defined values.
  task automatic add_rst(input logic [5:0] op, input logic rdy, input logic chk, input state_t st);
    vec_t v;
    v.rst = 1'b1; v.op = op; v.fn = '0; v.z = 1'b0; v.rdy = rdy;
    v.chk = chk; v.st = st; v.exp = '0; v.mask = m_en;
    vecs.push_back(v);
  endtask

  // Scoreboard checks
  task automatic check_vec(input string name, input logic [16:0] act, input logic [16:0] exp,
                           input logic [16:0] mask);
    n_cmp++;
    if (((act ^ exp) & mask) != 17'd0) begin
      n_bad++;
      $display("FAIL %s: got %b required %b (mask %b)", name, act & mask, exp & mask, mask);
    end
  endtask

  task automatic check_state(input string name, input state_t act, input state_t exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: state got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Driver: one cycle, inputs applied after the edge, outputs sampled at negedge.
  task automatic run_cycle(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic rdy);
    @(posedge clk);
    #1;
    reset = rst; opcode = op; funct = fn; zero = z; mem_ready = rdy;
    @(negedge clk);
  endtask

  logic [5:0] fn_list[4];
  logic [2:0] ac_list[4];

  initial begin
    m_all    = '1;
    m_en     = mk(1, 1, 0, 1, 1, 2'b00, 1, 0, 0, 0, 2'b00, 3'b000, 1);
    m_no_ill = ~mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 1);

    e_fetch_rdy  = mk(1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 2'b01, 3'b010, 0);
    e_fetch_wait = mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 3'b010, 0);
    e_decode     = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 3'b010, 0);
    e_decode_ill = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 3'b010, 1);
    e_memadr     = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 3'b010, 0);
    e_memrd      = mk(1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    e_memwb      = mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 3'b000, 0);
    e_memwr      = mk(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    e_aluwb      = mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 3'b000, 0);
    e_br1        = mk(0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 1, 2'b00, 3'b110, 0);
    e_br0        = mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 2'b00, 3'b110, 0);
    e_addiwb     = mk(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 3'b000, 0);
    e_jump       = mk(0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 2'b00, 3'b000, 0);

    // Reset for two cycles with mem_ready high: nothing may be enabled.
    add_rst(OP_RTYPE, 1'b1, 1'b0, S_FETCH);
    add_rst(OP_RTYPE, 1'b1, 1'b0, S_FETCH);

    // R-type sub: FETCH, DECODE, EXECUTE, ALUWB
    add(0, OP_RTYPE, FN_SUB, 0, 1, S_FETCH, e_fetch_rdy);
    add(0, OP_RTYPE, FN_SUB, 0, 1, S_DECODE, e_decode);
    add(0, OP_RTYPE, FN_SUB, 0, 1, S_EXECUTE, mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'b110, 0));
    add(0, OP_RTYPE, FN_SUB, 0, 1, S_ALUWB, e_aluwb);

    // lw with three wait states in MEMRD: 8 cycles total
    add(0, OP_LW, 6'h00, 0, 1, S_FETCH, e_fetch_rdy);
    add(0, OP_LW, 6'h00, 0, 1, S_DECODE, e_decode);
    add(0, OP_LW, 6'h00, 0, 1, S_MEMADR, e_memadr);
    for (int i = 0; i < 3; i++) add(0, OP_LW, 6'h00, 0, 0, S_MEMRD, e_memrd);
    add(0, OP_LW, 6'h00, 0, 1, S_MEMRD, e_memrd);
    add(0, OP_LW, 6'h00, 0, 1, S_MEMWB, e_memwb);

    // beq taken, then not taken
    add(0, OP_BEQ, 6'h00, 1, 1, S_FETCH, e_fetch_rdy);
    add(0, OP_BEQ, 6'h00, 1, 1, S_DECODE, e_decode);
    add(0, OP_BEQ, 6'h00, 1, 1, S_BRANCH, e_br1);
    add(0, OP_BEQ, 6'h00, 0, 1, S_FETCH, e_fetch_rdy);
    add(0, OP_BEQ, 6'h00, 0, 1, S_DECODE, e_decode);
    add(0, OP_BEQ, 6'h00, 0, 1, S_BRANCH, e_br0);

    // addi
    add(0, OP_ADDI, 6'h00, 0, 1, S_FETCH, e_fetch_rdy);
    add(0, OP_ADDI, 6'h00, 0, 1, S_DECODE, e_decode);
    add(0, OP_ADDI, 6'h00, 0, 1, S_ADDIEXEC, e_memadr);
    add(0, OP_ADDI, 6'h00, 0, 1, S_ADDIWB, e_addiwb);

    // j
    add(0, OP_J, 6'h00, 0, 1, S_FETCH, e_fetch_rdy);
    add(0, OP_J, 6'h00, 0, 1, S_DECODE, e_decode);
    add(0, OP_J, 6'h00, 0, 1, S_JUMP, e_jump);

    // sw with a fetch wait and a store wait; mem_ready low in DECODE/MEMADR is ignored
    add(0, OP_SW, 6'h00, 0, 0, S_FETCH, e_fetch_wait);
    add(0, OP_SW, 6'h00, 0, 1, S_FETCH, e_fetch_rdy);
    add(0, OP_SW, 6'h00, 0, 0, S_DECODE, e_decode);
    add(0, OP_SW, 6'h00, 0, 0, S_MEMADR, e_memadr);
    add(0, OP_SW, 6'h00, 0, 0, S_MEMWR, e_memwr);
    add(0, OP_SW, 6'h00, 0, 1, S_MEMWR, e_memwr);

    // Remaining R-type functs
    fn_list = '{FN_ADD, FN_AND, FN_OR, FN_SLT};
    ac_list = '{3'b010, 3'b000, 3'b001, 3'b111};
    for (int i = 0; i < 4; i++) begin
      add(0, OP_RTYPE, fn_list[i], 0, 1, S_FETCH, e_fetch_rdy);
      add(0, OP_RTYPE, fn_list[i], 0, 1, S_DECODE, e_decode);
      add(0, OP_RTYPE, fn_list[i], 0, 1, S_EXECUTE,
          mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, ac_list[i], 0));
      add(0, OP_RTYPE, fn_list[i], 0, 1, S_ALUWB, e_aluwb);
    end

    // Unknown opcode: DECODE flags it and returns to FETCH
    add(0, 6'b111111, 6'h00, 0, 1, S_FETCH, e_fetch_rdy);
    add(0, 6'b111111, 6'h00, 0, 1, S_DECODE, e_decode_ill);
    add(0, 6'b111111, 6'h00, 0, 0, S_FETCH, e_fetch_wait);
    add(0, 6'b111111, 6'h00, 0, 1, S_FETCH, e_fetch_rdy);

    // Unknown funct: executes as add and flags in EXECUTE only
    add(0, OP_RTYPE, 6'b111111, 0, 1, S_DECODE, e_decode);
    add(0, OP_RTYPE, 6'b111111, 0, 1, S_EXECUTE, mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'b010, 1));
    add(0, OP_RTYPE, 6'b111111, 0, 1, S_ALUWB, e_aluwb);

    // Reset while in MEMWR with mem_ready high: no store, back to FETCH
    add(0, OP_SW, 6'h00, 0, 1, S_FETCH, e_fetch_rdy);
    add(0, OP_SW, 6'h00, 0, 1, S_DECODE, e_decode);
    add(0, OP_SW, 6'h00, 0, 1, S_MEMADR, e_memadr);
    add_rst(OP_SW, 1'b1, 1'b1, S_MEMWR);
    add(0, OP_SW, 6'h00, 0, 0, S_FETCH, e_fetch_wait);

    // Reset while in ALUWB: no register write
    add(0, OP_RTYPE, FN_ADD, 0, 1, S_FETCH, e_fetch_rdy);
    add(0, OP_RTYPE, FN_ADD, 0, 1, S_DECODE, e_decode);
    add(0, OP_RTYPE, FN_ADD, 0, 1, S_EXECUTE, mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 3'b010, 0));
    add_rst(OP_RTYPE, 1'b1, 1'b1, S_ALUWB);
    add(0, OP_RTYPE, FN_ADD, 0, 0, S_FETCH, e_fetch_wait);

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
      check_vec($sformatf("row%0d_ctrl", i), act0, vecs[i].exp, vecs[i].mask);
      check_vec($sformatf("row%0d_ctrl_trap", i), act1, vecs[i].exp, vecs[i].mask & m_no_ill);
      if (vecs[i].chk) check_state($sformatf("row%0d_state", i), dbg_state0, vecs[i].st);
    end

    // Sticky illegal flag on the trapping instance. The resets above cleared it.
    run_cycle(0, 6'b111111, 6'h00, 0, 1);
    check_bit("trap_clear_fetch", illegal_op1, 1'b0);
    run_cycle(0, 6'b111111, 6'h00, 0, 1);
    check_state("trap_decode_state", dbg_state1, S_DECODE);
    check_bit("trap_decode_ill", illegal_op1, 1'b1);
    check_bit("pulse_decode_ill", illegal_op0, 1'b1);
    run_cycle(0, 6'b111111, 6'h00, 0, 0);
    check_bit("trap_sticky_1", illegal_op1, 1'b1);
    check_bit("pulse_gone_1", illegal_op0, 1'b0);
    run_cycle(0, 6'b111111, 6'h00, 0, 0);
    check_bit("trap_sticky_2", illegal_op1, 1'b1);
    run_cycle(1, OP_RTYPE, 6'h00, 0, 0);
    check_bit("trap_in_reset", illegal_op1, 1'b0);
    run_cycle(0, OP_RTYPE, 6'h00, 0, 0);
    check_bit("trap_after_reset", illegal_op1, 1'b0);
    check_state("trap_after_reset_state", dbg_state1, S_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
